// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M/RV64M multiply/divide unit.
//   One radix-2 datapath (shift-add multiply / restoring divide) shared by all
//   ops. Operands are converted to magnitudes on accept. Signs are re-applied
//   in FIX.
//   FSM: IDLE -> CALC (XLEN cycles) -> FIX (1 cycle) -> DONE (hold until taken).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_valid/ready request handshake (ready only in IDLE)
//   op                one-hot: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   rs1, rs2, tag_in  operands and destination tag
//   flush             kill in-flight op / pending result, back to IDLE
//   result_valid/ready, result, tag_out   response handshake and payload
//   busy              FSM not in IDLE
//
// Optional build macro: MDU_EARLY_OUT_EN
//   When defined, divide-by-zero, signed-overflow divides and multiplies with a
//   zero operand skip CALC and go straight from IDLE to FIX (latency 2).
module mdu_iterative #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [TAGW-1:0] tag_in,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      op_q, op_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [XLEN-1:0] mcand_q, mcand_d;   // multiplicand (mul) or divisor (div)
  logic [PW-1:0]   prod_q, prod_d;     // mul: {hi,lo} accumulator; div: {rem, quo}
  logic            negp_q, negp_d;     // negate product / quotient
  logic            negr_q, negr_d;     // negate remainder
  logic            div0_q, div0_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [TAGW-1:0] tag_out_q, tag_out_d;

  // ---------------- request decode ----------------
  logic            legal_in, is_mul_in, sgn_a, sgn_b, neg_a, neg_b, div0_in;
  logic [XLEN-1:0] abs_a, abs_b;

  assign legal_in  = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  assign is_mul_in = |op[3:0];
  assign sgn_a     = op[1] | op[2] | op[4] | op[6];
  assign sgn_b     = op[1] | op[4] | op[6];
  assign neg_a     = sgn_a & rs1[XLEN-1];
  assign neg_b     = sgn_b & rs2[XLEN-1];
  assign abs_a     = neg_a ? -rs1 : rs1;
  assign abs_b     = neg_b ? -rs2 : rs2;
  assign div0_in   = (rs2 == '0);

  logic          early_in;
  logic [PW-1:0] early_prod;
`ifdef MDU_EARLY_OUT_EN
  logic ovf_in, mzero_in;
  assign ovf_in   = (op[4] | op[6]) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign mzero_in = is_mul_in && ((rs1 == '0) || div0_in);
  assign early_in = legal_in && ((!is_mul_in && div0_in) || ovf_in || mzero_in);
  // Preload the final magnitudes so FIX produces the architectural answer:
  // div0 -> {rem=|a|, quo=ones}; overflow -> {rem=0, quo=|a|}; mul zero -> 0.
  always_comb begin
    early_prod = '0;
    if (!is_mul_in && div0_in) early_prod = {abs_a, {XLEN{1'b1}}};
    else if (ovf_in)           early_prod = {{XLEN{1'b0}}, abs_a};
  end
`else
  assign early_in   = 1'b0;
  assign early_prod = '0;
`endif

  // ---------------- shared adder ----------------
  // mul: {carry,hi} = hi + (lsb ? mcand : 0)
  // div: {rem,next dividend bit} - divisor, sign bit gives the borrow
  logic            is_mul_q;
  logic [XLEN:0]   div_tmp;
  logic [XLEN+1:0] add_a, add_b, sum;
  logic            cin, ge;

  assign is_mul_q = |op_q[3:0];
  assign div_tmp  = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
  assign add_a    = is_mul_q ? {2'b00, prod_q[PW-1:XLEN]} : {1'b0, div_tmp};
  assign add_b    = is_mul_q ? (prod_q[0] ? {2'b00, mcand_q} : '0) : ~{2'b00, mcand_q};
  assign cin      = !is_mul_q;
  assign sum      = add_a + add_b + {{(XLEN+1){1'b0}}, cin};
  assign ge       = !sum[XLEN+1];

  // ---------------- FIX result select ----------------
  logic [PW-1:0]   full;
  logic [XLEN-1:0] quo_v, rem_v, fix_res;

  assign full  = negp_q ? -prod_q : prod_q;
  assign quo_v = div0_q ? {XLEN{1'b1}}
               : (negp_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0]);
  assign rem_v = negr_q ? -prod_q[PW-1:XLEN] : prod_q[PW-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (illegal_q)                     fix_res = '0;
    else if (op_q[0])                  fix_res = full[XLEN-1:0];
    else if (|op_q[3:1])               fix_res = full[PW-1:XLEN];
    else if (op_q[4] | op_q[5])        fix_res = quo_v;
    else if (op_q[6] | op_q[7])        fix_res = rem_v;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    negp_d    = negp_q;
    negr_d    = negr_q;
    div0_d    = div0_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_valid) begin
          op_d      = op;
          tag_d     = tag_in;
          cnt_d     = '0;
          illegal_d = !legal_in;
          div0_d    = !is_mul_in && div0_in;
          negp_d    = neg_a ^ neg_b;
          negr_d    = neg_a;
          mcand_d   = is_mul_in ? abs_a : abs_b;
          prod_d    = {{XLEN{1'b0}}, (is_mul_in ? abs_b : abs_a)};
          state_d   = S_CALC;
          if (early_in) begin
            prod_d  = early_prod;
            state_d = S_FIX;
          end
        end
        S_CALC: begin
          if (is_mul_q)
            prod_d = {sum[XLEN:0], prod_q[XLEN-1:1]};
          else
            prod_d = {(ge ? sum[XLEN-1:0] : div_tmp[XLEN-1:0]), prod_q[XLEN-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        end
        S_FIX: begin
          result_d  = fix_res;
          tag_out_d = tag_q;
          state_d   = S_DONE;
        end
        default: if (result_ready) state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      negp_q    <= 1'b0;
      negr_q    <= 1'b0;
      div0_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      negp_q    <= negp_d;
      negr_q    <= negr_d;
      div0_q    <= div0_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign tag_out      = tag_out_q;

endmodule
